// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared parameters and types for the accelerator frame memory
package acc_pkg;

  localparam int SImgSize       = 31;
  localparam int SMemDataWidth  = 8;
  localparam int SMemDepth      = SImgSize * SImgSize;
  localparam int SMemAddrWidth  = $clog2(SMemDepth);
  localparam int SMemNumRdPorts = 4;

  typedef enum logic [1:0] {
    SMEM_IDLE  = 2'd0,
    SMEM_LOAD  = 2'd1,
    SMEM_READY = 2'd2
  } smem_state_e;

  typedef struct packed {
    logic [SMemNumRdPorts-1:0]               rd_en;
    logic [SMemNumRdPorts*SMemAddrWidth-1:0] rd_addr;
  } smem_req_t;

  typedef struct packed {
    logic [SMemNumRdPorts-1:0]               rd_valid;
    logic [SMemNumRdPorts-1:0]               rd_err;
    logic [SMemNumRdPorts*SMemDataWidth-1:0] rd_data;
  } smem_res_t;

endpackage

// File: rtl/smem_array.sv
// rtl/smem_array.sv - one-write multi-read storage with registered, write-first reads
module smem_array
  import acc_pkg::*;
#(
  parameter int DataWidth  = SMemDataWidth,
  parameter int Depth      = SMemDepth,
  parameter int NumRdPorts = SMemNumRdPorts,
  parameter int AddrWidth  = $clog2(Depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [AddrWidth-1:0]           waddr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic [NumRdPorts-1:0]          re_i,
  input  logic [NumRdPorts-1:0]          rzero_i,
  input  logic [NumRdPorts*AddrWidth-1:0] raddr_i,
  output logic [NumRdPorts*DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem     [Depth];
  logic [DataWidth-1:0] rdata_q [NumRdPorts];

  // Storage write; contents deliberately survive reset so a frame stays readable.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read registers: zero for rejected addresses, bypass the same-cycle write, else hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumRdPorts; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NumRdPorts; p++) begin
        if (re_i[p]) begin
          if (rzero_i[p]) begin
            rdata_q[p] <= '0;
          end else if (we_i && (waddr_i == raddr_i[p*AddrWidth +: AddrWidth])) begin
            rdata_q[p] <= wdata_i;
          end else begin
            rdata_q[p] <= mem[raddr_i[p*AddrWidth +: AddrWidth]];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NumRdPorts; p++) begin : g_rdata
    assign rdata_o[p*DataWidth +: DataWidth] = rdata_q[p];
  end

endmodule

// File: rtl/smem_mp.sv
// rtl/smem_mp.sv - frame memory with streamed load and multiple independent read ports
module smem_mp
  import acc_pkg::*;
#(
  parameter int DataWidth    = SMemDataWidth,
  parameter int Depth        = SMemDepth,
  parameter int NumRdPorts   = SMemNumRdPorts,
  localparam int AddrWidth   = $clog2(Depth)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_start_i,
  input  logic                            ld_valid_i,
  input  logic [DataWidth-1:0]            ld_data_i,
  output logic                            ld_ready_o,
  output logic                            loaded_o,
  input  logic [NumRdPorts-1:0]           rd_en_i,
  input  logic [NumRdPorts*AddrWidth-1:0] rd_addr_i,
  output logic [NumRdPorts*DataWidth-1:0] rd_data_o,
  output logic [NumRdPorts-1:0]           rd_valid_o,
  output logic [NumRdPorts-1:0]           rd_err_o
);

  localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth:0]   DepthLimit = (AddrWidth + 1)'(Depth);

  smem_state_e          state_q, state_d;
  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic                 loaded_q, loaded_d;
  logic                 wr_en;
  logic [NumRdPorts-1:0] rd_oor;
  logic [NumRdPorts-1:0] rd_valid_q, rd_err_q;

  // Next state, load handshake and pointer advance; a start always wins over a beat.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    loaded_d   = loaded_q;
    ld_ready_o = 1'b0;
    wr_en      = 1'b0;
    if (load_start_i) begin
      state_d  = SMEM_LOAD;
      ptr_d    = '0;
      loaded_d = 1'b0;
    end else if (state_q == SMEM_LOAD) begin
      ld_ready_o = 1'b1;
      if (ld_valid_i) begin
        wr_en = 1'b1;
        if (ptr_q == LastAddr) begin
          state_d  = SMEM_READY;
          loaded_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end
  end

  // State, load pointer and frame-resident flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SMEM_IDLE;
      ptr_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
    end
  end

  for (genvar p = 0; p < NumRdPorts; p++) begin : g_range
    assign rd_oor[p] = {1'b0, rd_addr_i[p*AddrWidth +: AddrWidth]} >= DepthLimit;
  end

  // Per-port valid and out-of-range flags, aligned with the registered read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= '0;
      rd_err_q   <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      rd_err_q   <= rd_en_i & rd_oor;
    end
  end

  smem_array #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .NumRdPorts(NumRdPorts),
    .AddrWidth (AddrWidth)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_en),
    .waddr_i(ptr_q),
    .wdata_i(ld_data_i),
    .re_i   (rd_en_i),
    .rzero_i(rd_oor),
    .raddr_i(rd_addr_i),
    .rdata_o(rd_data_o)
  );

  assign loaded_o   = loaded_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_smem_mp.sv
// tb/tb_smem_mp.sv - self-checking bench for smem_mp
module tb_smem_mp;

  localparam int DEPTH = 961;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready_o;
  logic        loaded_o;
  logic [3:0]  rd_en;
  logic [39:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  rd_err;

  smem_mp dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_start_i(load_start),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready_o),
    .loaded_o    (loaded_o),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_err_o    (rd_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_cnt = 0;

  // reference model: frame contents, load progress and expected read results
  logic [7:0] m_mem   [1024];
  bit         m_known [1024];
  int         m_ptr;
  bit         m_loading;
  bit         m_loaded;
  logic [7:0] e_data  [4];
  bit         e_known [4];
  logic [3:0] e_valid;
  logic [3:0] e_err;

  typedef struct packed {
    logic [3:0]  en;
    logic [39:0] addr;
    logic [31:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_addr(input int p, input int a);
    rd_addr[p*10 +: 10] = 10'(a);
  endtask

  task automatic rand_reads();
    rd_en = 4'($urandom);
    for (int p = 0; p < 4; p++) begin
      if ($urandom_range(0, 7) == 0) set_addr(p, $urandom_range(DEPTH, 1023));
      else set_addr(p, $urandom_range(0, DEPTH - 1));
    end
    if ($urandom_range(0, 3) == 0) set_addr(1, rd_addr[9:0]);
  endtask

  task automatic model_reset();
    m_loading = 0;
    m_loaded  = 0;
    e_valid   = '0;
    e_err     = '0;
    for (int p = 0; p < 4; p++) begin
      e_data[p]  = '0;
      e_known[p] = 1;
    end
  endtask

  // one clock cycle with the currently driven inputs, checked against the model
  task automatic tick();
    bit wr;
    int a;
    #1;
    chk("ld_ready", ld_ready_o, m_loading && !load_start);
    if (ld_ready_o) rdy_cnt++;
    wr = m_loading && !load_start && ld_valid;
    for (int p = 0; p < 4; p++) begin
      if (rd_en[p]) begin
        a = int'(rd_addr[p*10 +: 10]);
        e_valid[p] = 1'b1;
        if (a >= DEPTH) begin
          e_data[p] = '0; e_known[p] = 1; e_err[p] = 1'b1;
        end else if (wr && a == m_ptr) begin
          e_data[p] = ld_data; e_known[p] = 1; e_err[p] = 1'b0;
        end else begin
          e_data[p] = m_mem[a]; e_known[p] = m_known[a]; e_err[p] = 1'b0;
        end
      end else begin
        e_valid[p] = 1'b0;
        e_err[p]   = 1'b0;
      end
    end
    if (load_start) begin
      m_loading = 1; m_ptr = 0; m_loaded = 0;
    end else if (wr) begin
      m_mem[m_ptr] = ld_data;
      m_known[m_ptr] = 1;
      m_ptr++;
      if (m_ptr == DEPTH) begin
        m_loading = 0; m_loaded = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("loaded", loaded_o, m_loaded);
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_err", rd_err, e_err);
    for (int p = 0; p < 4; p++) begin
      if (e_known[p]) chk($sformatf("rd_data%0d", p), rd_data[p*8 +: 8], e_data[p]);
    end
  endtask

  initial begin
    int beats;
    int cycles;
    logic [7:0] first_beat;

    for (int i = 0; i < 1024; i++) m_known[i] = 0;
    vt[0] = '{en: 4'b1111, addr: {10'd960, 10'd480, 10'd31, 10'd0},
              d: {8'd192, 8'd224, 8'd31, 8'd0}, v: 4'b1111, e: 4'b0000};
    vt[1] = '{en: 4'b0010, addr: {10'd0, 10'd0, 10'd1000, 10'd0},
              d: {8'd192, 8'd224, 8'd0, 8'd0}, v: 4'b0010, e: 4'b0010};
    vt[2] = '{en: 4'b0000, addr: {10'd0, 10'd0, 10'd1000, 10'd0},
              d: {8'd192, 8'd224, 8'd0, 8'd0}, v: 4'b0000, e: 4'b0000};
    vt[3] = '{en: 4'b1111, addr: {10'd960, 10'd960, 10'd960, 10'd960},
              d: {8'd192, 8'd192, 8'd192, 8'd192}, v: 4'b1111, e: 4'b0000};
    vt[4] = '{en: 4'b1111, addr: {10'd1023, 10'd3, 10'd2, 10'd1},
              d: {8'd0, 8'd3, 8'd2, 8'd1}, v: 4'b1111, e: 4'b1000};
    vt[5] = '{en: 4'b0001, addr: {10'd0, 10'd0, 10'd0, 10'd31},
              d: {8'd0, 8'd3, 8'd2, 8'd31}, v: 4'b0001, e: 4'b0000};

    rst = 1; load_start = 0; ld_valid = 0; ld_data = '0; rd_en = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ld_ready", ld_ready_o, 1'b0);
    chk("reset_loaded", loaded_o, 1'b0);
    chk("reset_rd_valid", rd_valid, 4'b0);
    chk("reset_rd_err", rd_err, 4'b0);
    chk("reset_rd_data", rd_data, 32'h0);
    rst = 0;
    model_reset();
    tick();

    // full frame streamed back-to-back, with a write-first probe on port 2
    load_start = 1; tick(); load_start = 0;
    rdy_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1;
      ld_data  = (i == 5) ? 8'hAB : 8'(i);
      rd_en    = (i == 5) ? 4'b0100 : 4'b0000;
      set_addr(2, 5);
      tick();
      if (i == 5)   chk("write_first_p2", rd_data[23:16], 8'hAB);
      if (i == 959) chk("loaded_before_last", loaded_o, 1'b0);
      if (i == 960) chk("loaded_after_last", loaded_o, 1'b1);
    end
    ld_valid = 0; rd_en = '0;
    chk("ready_cycles", rdy_cnt, DEPTH);

    // table vectors: simultaneous reads, out of range, hold
    for (int k = 0; k < 6; k++) begin
      rd_en = vt[k].en; rd_addr = vt[k].addr;
      tick();
      chk($sformatf("vec%0d_data", k), rd_data, vt[k].d);
      chk($sformatf("vec%0d_valid", k), rd_valid, vt[k].v);
      chk($sformatf("vec%0d_err", k), rd_err, vt[k].e);
    end

    // restart after 100 beats while ld_valid stays high
    load_start = 1; rd_en = '0; tick(); load_start = 0;
    for (int i = 0; i < 100; i++) begin
      ld_valid = 1; ld_data = 8'($urandom); rand_reads(); tick();
    end
    load_start = 1; ld_valid = 1; ld_data = 8'($urandom); rd_en = '0;
    #1;
    chk("restart_no_accept", ld_ready_o, 1'b0);
    tick();
    load_start = 0;
    beats = 0; cycles = 0; first_beat = '0;
    while (beats < DEPTH && cycles < 5000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = 8'($urandom);
      rand_reads();
      if (ld_valid && beats == 0) first_beat = ld_data;
      if (ld_valid) beats++;
      cycles++;
      tick();
    end
    chk("restart_beats", beats, DEPTH);
    chk("loaded_after_restart", loaded_o, 1'b1);
    ld_valid = 0; rd_en = 4'b0001; set_addr(0, 0);
    tick();
    chk("restart_addr0", rd_data[7:0], first_beat);

    // reset asserted between edges in the middle of a load
    load_start = 1; rd_en = '0; tick(); load_start = 0;
    for (int i = 0; i < 50; i++) begin
      ld_valid = 1; ld_data = 8'($urandom); rand_reads(); tick();
    end
    rd_en = 4'b1111; set_addr(0, 10); set_addr(1, 20); set_addr(2, 30); set_addr(3, 40);
    tick();
    #2;
    rst = 1;
    #1;
    chk("midrst_ld_ready", ld_ready_o, 1'b0);
    chk("midrst_rd_valid", rd_valid, 4'b0);
    chk("midrst_rd_err", rd_err, 4'b0);
    chk("midrst_rd_data", rd_data, 32'h0);
    chk("midrst_loaded", loaded_o, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    ld_valid = 1; ld_data = 8'h5A;
    rd_en = 4'b1111; set_addr(0, 0); set_addr(1, 49); set_addr(2, 500); set_addr(3, 960);
    tick();
    set_addr(0, m_ptr); set_addr(1, 51);
    tick();
    ld_valid = 0;

    // random traffic with occasional restarts
    for (int i = 0; i < 600; i++) begin
      load_start = ($urandom_range(0, 149) == 0);
      ld_valid   = ($urandom_range(0, 1) != 0);
      ld_data    = 8'($urandom);
      rand_reads();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
